// File: rtl/cva6_pma_region_table.sv
// cva6_pma_region_table
//   Runtime-programmable physical-memory-attribute table. NrRegions software-writable
//   entries (BASE, LENGTH, ATTR) classify one physical address per cycle as
//   cached / executable / non-idempotent.
//
// Ports
//   clk_i, rst_ni                 clock, asynchronous active-low reset
//   cfg_req_i/we_i/addr_i/wdata_i config access; addr = {region idx, offset}
//                                 offset 0=BASE, 1=LENGTH, 2=ATTR, 3=reserved
//   cfg_rvalid_o/rdata_o/err_o    config response, exactly one cycle after the request
//   chk_valid_i/ready_o/addr_i    lookup request (valid/ready handshake)
//   rsp_valid_o/ready_i           lookup result handshake (one output register)
//   rsp_hit_o/idx_o/cached_o/exec_o/nonidem_o  lookup result fields
//
// ATTR layout: [0] en, [1] cached, [2] exec, [3] nonidem, [7] lock; other bits read 0.

module cva6_pma_region_table #(
    parameter int unsigned          NrRegions     = 4,
    parameter int unsigned          AddrWidth     = 64,
    parameter logic [AddrWidth-1:0] Region0Base   = AddrWidth'(64'h8000_0000),
    parameter logic [AddrWidth-1:0] Region0Length = AddrWidth'(64'h4000_0000),
    parameter logic [7:0]           Region0Attr   = 8'h07,
    localparam int unsigned         IdxW          = (NrRegions > 1) ? $clog2(NrRegions) : 1
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 cfg_req_i,
    input  logic                 cfg_we_i,
    input  logic [IdxW+1:0]      cfg_addr_i,
    input  logic [AddrWidth-1:0] cfg_wdata_i,
    output logic                 cfg_rvalid_o,
    output logic [AddrWidth-1:0] cfg_rdata_o,
    output logic                 cfg_err_o,
    input  logic                 chk_valid_i,
    output logic                 chk_ready_o,
    input  logic [AddrWidth-1:0] chk_addr_i,
    output logic                 rsp_valid_o,
    input  logic                 rsp_ready_i,
    output logic                 rsp_hit_o,
    output logic [IdxW-1:0]      rsp_idx_o,
    output logic                 rsp_cached_o,
    output logic                 rsp_exec_o,
    output logic                 rsp_nonidem_o
);

    localparam logic [7:0] AttrMask = 8'h8F;
    localparam int unsigned BitEn      = 0;
    localparam int unsigned BitCached  = 1;
    localparam int unsigned BitExec    = 2;
    localparam int unsigned BitNonidem = 3;
    localparam int unsigned BitLock    = 7;

    logic [AddrWidth-1:0] base_q [NrRegions];
    logic [AddrWidth-1:0] len_q  [NrRegions];
    logic [7:0]           attr_q [NrRegions];

    // ---------------- configuration port ----------------
    logic [IdxW-1:0]      cfg_idx;
    logic [1:0]           cfg_off;
    logic                 cfg_idx_ok;
    logic                 cfg_lock;
    logic                 cfg_err;
    logic                 cfg_write;
    logic [AddrWidth-1:0] cfg_read_val;

    assign cfg_idx    = cfg_addr_i[IdxW+1:2];
    assign cfg_off    = cfg_addr_i[1:0];
    // Guards non-power-of-two tables where the index field can name a missing entry.
    assign cfg_idx_ok = ({1'b0, cfg_idx} < (IdxW+1)'(NrRegions));
    assign cfg_lock   = cfg_idx_ok & attr_q[cfg_idx][BitLock];
    assign cfg_err    = !cfg_idx_ok | (cfg_off == 2'd3) | (cfg_we_i & cfg_lock);
    assign cfg_write  = cfg_req_i & cfg_we_i & !cfg_err;

    // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        cfg_read_val = '0;
        if (cfg_idx_ok) begin
            case (cfg_off)
                2'd0:    cfg_read_val = base_q[cfg_idx];
                2'd1:    cfg_read_val = len_q[cfg_idx];
                2'd2:    cfg_read_val = AddrWidth'(attr_q[cfg_idx]);
                default: cfg_read_val = '0;
            endcase
        end
    end

    // NOTE: the table is a handful of flops, not a RAM macro, so it is reset like any register;
    // entry 0 comes up describing DRAM so the core can boot before software programs anything.
    // NOTE: sequential state uses non-blocking assignments only, so every reader sees the
    // pre-edge value -- this is what makes a same-cycle lookup see the pre-write table.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(NrRegions); i++) begin
                base_q[i] <= (i == 0) ? Region0Base : '0;
                len_q[i]  <= (i == 0) ? Region0Length : '0;
                attr_q[i] <= (i == 0) ? (Region0Attr & AttrMask) : '0;
            end
        end else if (cfg_write) begin
            case (cfg_off)
                2'd0:    base_q[cfg_idx] <= cfg_wdata_i;
                2'd1:    len_q[cfg_idx]  <= cfg_wdata_i;
                2'd2:    attr_q[cfg_idx] <= cfg_wdata_i[7:0] & AttrMask;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cfg_rvalid_o <= 1'b0;
            cfg_rdata_o  <= '0;
            cfg_err_o    <= 1'b0;
        end else begin
            cfg_rvalid_o <= cfg_req_i;
            cfg_err_o    <= cfg_req_i & cfg_err;
            cfg_rdata_o  <= (cfg_req_i && !cfg_we_i && !cfg_err) ? cfg_read_val : '0;
        end
    end

    // ---------------- lookup ----------------
    logic            hit;
    logic [IdxW-1:0] hit_idx;
    logic            hit_cached;
    logic            hit_exec;
    logic            hit_nonidem;

    // Walk from the top entry down so the lowest matching index is the last one written.
    // The subtraction form keeps BASE+LENGTH wrap-around correct without extra logic.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = int'(NrRegions) - 1; i >= 0; i--) begin
            if (attr_q[i][BitEn] && (chk_addr_i >= base_q[i]) &&
                ((chk_addr_i - base_q[i]) < len_q[i])) begin
                hit     = 1'b1;
                hit_idx = IdxW'(i);
            end
        end
        // A miss is reported as non-idempotent so nothing speculates into unknown space.
        hit_cached  = hit & attr_q[hit_idx][BitCached];
        hit_exec    = hit & attr_q[hit_idx][BitExec];
        hit_nonidem = !hit | attr_q[hit_idx][BitNonidem];
    end

    logic transfer;
    assign chk_ready_o = !rsp_valid_o | rsp_ready_i;
    assign transfer    = chk_valid_i & chk_ready_o;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rsp_valid_o   <= 1'b0;
            rsp_hit_o     <= 1'b0;
            rsp_idx_o     <= '0;
            rsp_cached_o  <= 1'b0;
            rsp_exec_o    <= 1'b0;
            rsp_nonidem_o <= 1'b0;
        end else if (transfer) begin
            rsp_valid_o   <= 1'b1;
            rsp_hit_o     <= hit;
            rsp_idx_o     <= hit_idx;
            rsp_cached_o  <= hit_cached;
            rsp_exec_o    <= hit_exec;
            rsp_nonidem_o <= hit_nonidem;
        end else if (rsp_ready_i) begin
            rsp_valid_o   <= 1'b0;
        end
    end

endmodule
